ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Sequences a single external RAM port shared by three requesters: the video scanner, the 6502 CPU path (after language-card and auxiliary-bank address translation), and a DMA/loader port. Arbitrates with fixed priority (video > CPU > DMA) plus a starvation guard for DMA. Runs each access through a fixed-latency state machine and returns read data with a one-cycle acknowledge. Sits between the bank-mapping logic and the memory pins/BRAM wrapper.

## Interface
- `AW`, 17: RAM address width, `{aux, addr[15:0]}`.
- `DW`, 8: data width.
- `LATENCY`, 2: cycles the RAM needs per access; legal range 1..15.
- `DMA_MAX_SKIP`, 4: grants DMA may lose to CPU before it is promoted; range 1..15.

- `mclk28`  in  1  system clock
- `reset_in_n`  in  1  asynchronous, active-low reset
- `vid_req`  in  1  video read request (level)
- `vid_addr`  in  AW  video address
- `vid_ack`  out  1  one-cycle done pulse; `vid_rdata` valid
- `vid_rdata`  out  DW  video read data
- `cpu_req`, `cpu_we`, `cpu_wprot`  in  1 each  CPU request, write, write-protected (language-card write disabled)
- `cpu_addr`  in  AW;  `cpu_wdata`  in  DW
- `cpu_ack`  out  1;  `cpu_rdata`  out  DW
- `dma_req`, `dma_we`  in  1 each;  `dma_addr`  in  AW;  `dma_wdata`  in  DW
- `dma_ack`  out  1;  `dma_rdata`  out  DW
- `ram_cs`, `ram_we`  out  1 each;  `ram_addr`  out  AW;  `ram_wdata`  out  DW;  `ram_rdata`  in  DW
- `busy`  out  1  state is not IDLE
- `owner`  out  2  current owner (NONE/VID/CPU/DMA)

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: sample requests; winner is video if `vid_req`; else DMA if `dma_req` and `skip_cnt == DMA_MAX_SKIP`; else CPU if `cpu_req`; else DMA if `dma_req`. On any winner: latch the address, write enable and write data into output registers, set `owner`, go to ACCESS. With no request, stay in IDLE.
- ACCESS: `ram_cs=1` for exactly LATENCY cycles (counter). `ram_we` = latched write AND NOT (owner CPU AND `cpu_wprot`). Video is always a read. On the last ACCESS cycle, capture `ram_rdata` into the owner's rdata register, then go to DONE.
- DONE: the owner's ack is high for one cycle. Go to IDLE. Requests are never sampled in DONE.
- Requester rule: hold req, addr, we and wdata stable until ack. Deassert req on the edge that ends ack. A req still high in the following IDLE cycle counts as a new access.
- `skip_cnt`: increments (saturating at DMA_MAX_SKIP) on each CPU grant made while `dma_req` is high. Clears on a DMA grant. Video grants leave it unchanged.
- A write-protected CPU write performs no RAM write but is still acknowledged. Its `cpu_rdata` is undefined.
- rdata registers hold their value until the next access by the same owner.

## Timing
- req sampled in IDLE at cycle 0. ACCESS occupies cycles 1..LATENCY. ack appears at cycle LATENCY+1. IDLE at LATENCY+2.
- Peak throughput: one access per LATENCY+2 cycles.
- Reset (asynchronous, any state including mid-ACCESS) gives: state IDLE; `ram_cs=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`; all acks 0; all rdata 0; `skip_cnt=0`; `owner=NONE`; `busy=0`. An in-flight access is dropped and not acknowledged.
- Simultaneous requests are resolved only by the priority rule. Request changes during ACCESS or DONE are ignored.

## Configuration
- `RAM_ARB_DMA_EN`: when defined, the DMA port and the starvation guard are present.
- When undefined: the DMA ports remain on the module, but `dma_ack` and `dma_rdata` are tied to 0, `dma_req` is ignored, and `skip_cnt` logic is removed.

## Structure
- Package `ram_arb_pkg` holds:
  - owner encoding: `OWN_NONE=0`, `OWN_VID=1`, `OWN_CPU=2`, `OWN_DMA=3`
  - state encoding: IDLE, ACCESS, DONE
  - width constant for the LATENCY counter (4 bits)
- Sub-module `ram_arb_prio`: combinational winner selection plus the registered `skip_cnt`. Inputs are the three reqs and a grant strobe; output is the winner code.

## Test plan
- Video reads `17'h02000`, LATENCY=2, RAM returns `8'hA5` -> `ram_cs` high on cycles 1–2, `vid_ack` on cycle 3 with `vid_rdata=8'hA5`, `busy` low at cycle 4.
- `vid_req` and `cpu_req` rise together -> video served first; CPU served in the next IDLE; `cpu_ack` on cycle 7.
- CPU write of `8'h3C` to `17'h1D000` with `cpu_wprot=1` -> `ram_we` stays 0 throughout, `cpu_ack` still pulses once.
- `cpu_req` and `dma_req` held continuously, DMA_MAX_SKIP=4 -> grant order CPU, CPU, CPU, CPU, DMA, CPU…
- Assert `reset_in_n=0` in the second ACCESS cycle of a CPU write -> `ram_cs` and `ram_we` drop immediately, no `cpu_ack`, `owner=NONE`.
- Build without `RAM_ARB_DMA_EN`, drive only `dma_req` -> `busy` never rises, `dma_ack` stays 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared encodings for the RAM arbiter: owner codes, FSM states, latency counter width.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/ram_arb_prio.sv
// Fixed-priority winner selection (video > CPU > DMA) with a DMA starvation guard.
// The DMA path and skip counter exist only when RAM_ARB_DMA_EN is defined.
module ram_arb_prio
  import ram_arb_pkg::*;
#(
  parameter int DMA_MAX_SKIP = 4
) (
  input  logic   mclk28,
  input  logic   reset_in_n,
  input  logic   vid_req,
  input  logic   cpu_req,
  input  logic   dma_req,
  input  logic   grant,
  output owner_t winner
);

`ifdef RAM_ARB_DMA_EN
  localparam logic [3:0] SKIP_MAX = 4'(DMA_MAX_SKIP);

  logic [3:0] skip_cnt;

  always_comb begin
    winner = OWN_NONE;
    if (vid_req)
      winner = OWN_VID;
    else if (dma_req && (skip_cnt == SKIP_MAX))
      winner = OWN_DMA;
    else if (cpu_req)
      winner = OWN_CPU;
    else if (dma_req)
      winner = OWN_DMA;
  end

  // Counts CPU grants that bypassed a waiting DMA; video grants do not count.
  always_ff @(posedge mclk28 or negedge reset_in_n) begin
    if (!reset_in_n) begin
      skip_cnt <= '0;
    end else if (grant) begin
      if (winner == OWN_DMA)
        skip_cnt <= '0;
      else if ((winner == OWN_CPU) && dma_req && (skip_cnt != SKIP_MAX))
        skip_cnt <= skip_cnt + 4'd1;
    end
  end
`else
  localparam int unused_skip_max = DMA_MAX_SKIP;
  logic unused_prio;
  assign unused_prio = ^{mclk28, reset_in_n, dma_req, grant};

  always_comb begin
    winner = OWN_NONE;
    if (vid_req)
      winner = OWN_VID;
    else if (cpu_req)
      winner = OWN_CPU;
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between video, CPU and DMA requesters with a fixed-latency access FSM.
// Optional DMA port and starvation guard: RAM_ARB_DMA_EN.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW           = 17,
  parameter int DW           = 8,
  parameter int LATENCY      = 2,
  parameter int DMA_MAX_SKIP = 4
) (
  input  logic          mclk28,
  input  logic          reset_in_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_wprot,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic [1:0]    owner,
  output logic [1:0]    dbg_state
);

  // Handshake: a requester raises req with addr/we/wdata stable and holds them until
  // its one-cycle ack; req still high in the following IDLE cycle is a new access.

  localparam logic [LAT_CNT_W-1:0] LAST_CNT = LAT_CNT_W'(LATENCY - 1);

  state_t                 state_q, state_d;
  owner_t                 owner_q, winner;
  logic [LAT_CNT_W-1:0]   lat_cnt;
  logic                   we_q;
  logic                   grant;
  logic                   last_beat;

  assign grant     = (state_q == ST_IDLE);
  assign last_beat = (state_q == ST_ACCESS) && (lat_cnt == LAST_CNT);

  ram_arb_prio #(
    .DMA_MAX_SKIP (DMA_MAX_SKIP)
  ) u_prio (
    .mclk28     (mclk28),
    .reset_in_n (reset_in_n),
    .vid_req    (vid_req),
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .grant      (grant),
    .winner     (winner)
  );

  always_ff @(posedge mclk28 or negedge reset_in_n) begin
    if (!reset_in_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (winner != OWN_NONE) state_d = ST_ACCESS;
      ST_ACCESS: if (last_beat) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk28 or negedge reset_in_n) begin
    if (!reset_in_n) begin
      owner_q   <= OWN_NONE;
      lat_cnt   <= '0;
      we_q      <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      vid_rdata <= '0;
      cpu_rdata <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          lat_cnt <= '0;
          if (winner != OWN_NONE)
            owner_q <= winner;
          case (winner)
            OWN_VID: begin
              ram_addr <= vid_addr;
              we_q     <= 1'b0;
            end
            OWN_CPU: begin
              ram_addr  <= cpu_addr;
              ram_wdata <= cpu_wdata;
              we_q      <= cpu_we;
            end
            OWN_DMA: begin
              ram_addr  <= dma_addr;
              ram_wdata <= dma_wdata;
              we_q      <= dma_we;
            end
            default: ;
          endcase
        end
        ST_ACCESS: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (last_beat) begin
            if (owner_q == OWN_VID) vid_rdata <= ram_rdata;
            if (owner_q == OWN_CPU) cpu_rdata <= ram_rdata;
          end
        end
        ST_DONE: begin
          owner_q <= OWN_NONE;
          we_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef RAM_ARB_DMA_EN
  logic [DW-1:0] dma_rdata_q;

  always_ff @(posedge mclk28 or negedge reset_in_n) begin
    if (!reset_in_n)
      dma_rdata_q <= '0;
    else if (last_beat && (owner_q == OWN_DMA))
      dma_rdata_q <= ram_rdata;
  end

  assign dma_ack   = (state_q == ST_DONE) && (owner_q == OWN_DMA);
  assign dma_rdata = dma_rdata_q;
`else
  assign dma_ack   = 1'b0;
  assign dma_rdata = '0;
`endif

  // A write-protected CPU write still runs the cycle, just without the strobe.
  assign ram_cs    = (state_q == ST_ACCESS);
  assign ram_we    = ram_cs && we_q && !((owner_q == OWN_CPU) && cpu_wprot);
  assign vid_ack   = (state_q == ST_DONE) && (owner_q == OWN_VID);
  assign cpu_ack   = (state_q == ST_DONE) && (owner_q == OWN_CPU);
  assign busy      = (state_q != ST_IDLE);
  assign owner     = owner_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: vector table of single accesses plus hand-written
// priority, write-protect, reset and DMA sequences (DMA checks follow RAM_ARB_DMA_EN).
module tb_ram_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;

  logic          mclk28;
  logic          reset_in_n;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack;
  logic [DW-1:0] vid_rdata;
  logic          cpu_req, cpu_we, cpu_wprot;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          busy;
  logic [1:0]    owner;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_vid_rd;
  logic [1:0]    exp_q[$];

  ram_arbiter #(
    .AW(AW), .DW(DW), .LATENCY(2), .DMA_MAX_SKIP(4)
  ) dut (
    .mclk28(mclk28), .reset_in_n(reset_in_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_wprot(cpu_wprot), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  // clock / reset
  initial mclk28 = 1'b0;
  always #5 mclk28 = ~mclk28;

  typedef struct {
    logic          v, c, d, we, wprot, chk_rd;
    logic [AW-1:0] av, ac, ad;
    logic [DW-1:0] wdata, rdata;
    logic [1:0]    exp_owner;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic c, logic d, logic we, logic wprot, logic chk_rd,
                              logic [AW-1:0] av, logic [AW-1:0] ac, logic [AW-1:0] ad,
                              logic [DW-1:0] wdata, logic [DW-1:0] rdata,
                              logic [1:0] exp_owner, logic exp_we, logic [AW-1:0] exp_addr);
    vec_t r;
    r.v = v; r.c = c; r.d = d; r.we = we; r.wprot = wprot; r.chk_rd = chk_rd;
    r.av = av; r.ac = ac; r.ad = ad; r.wdata = wdata; r.rdata = rdata;
    r.exp_owner = exp_owner; r.exp_we = exp_we; r.exp_addr = exp_addr;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge mclk28);
    #1;
  endtask

  task automatic idle_inputs();
    vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    cpu_we = 1'b0; cpu_wprot = 1'b0; dma_we = 1'b0;
    vid_addr = '0; cpu_addr = '0; dma_addr = '0;
    cpu_wdata = '0; dma_wdata = '0; ram_rdata = '0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [2:0]    exp_ack;
    logic [DW-1:0] own_rd;
    vid_req = v.v; cpu_req = v.c; dma_req = v.d;
    cpu_we = v.we; dma_we = v.we; cpu_wprot = v.wprot;
    vid_addr = v.av; cpu_addr = v.ac; dma_addr = v.ad;
    cpu_wdata = v.wdata; dma_wdata = v.wdata; ram_rdata = v.rdata;
    tick();
    check($sformatf("v%0d_owner", idx), 32'(owner), 32'(v.exp_owner));
    check($sformatf("v%0d_cs1", idx), 32'(ram_cs), 32'd1);
    check($sformatf("v%0d_we", idx), 32'(ram_we), 32'(v.exp_we));
    check($sformatf("v%0d_addr", idx), 32'(ram_addr), 32'(v.exp_addr));
    if (v.exp_we) check($sformatf("v%0d_wdata", idx), 32'(ram_wdata), 32'(v.wdata));
    tick();
    check($sformatf("v%0d_cs2", idx), 32'(ram_cs), 32'd1);
    check($sformatf("v%0d_noack", idx), 32'({vid_ack, cpu_ack, dma_ack}), 32'd0);
    tick();
    case (v.exp_owner)
      2'd1:    begin exp_ack = 3'b100; own_rd = vid_rdata; exp_vid_rd = v.rdata; end
      2'd2:    begin exp_ack = 3'b010; own_rd = cpu_rdata; end
      default: begin exp_ack = 3'b001; own_rd = dma_rdata; end
    endcase
    check($sformatf("v%0d_ack", idx), 32'({vid_ack, cpu_ack, dma_ack}), 32'(exp_ack));
    check($sformatf("v%0d_cs_off", idx), 32'(ram_cs), 32'd0);
    if (v.chk_rd) check($sformatf("v%0d_rdata", idx), 32'(own_rd), 32'(v.rdata));
    check($sformatf("v%0d_vid_hold", idx), 32'(vid_rdata), 32'(exp_vid_rd));
    vid_req = 1'b0; cpu_req = 1'b0; dma_req = 1'b0;
    tick();
    check($sformatf("v%0d_busy_end", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    int we_cnt, ack_cnt, busy_cnt;
    idle_inputs();
    reset_in_n = 1'b0;
    exp_vid_rd = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_ram", 32'({ram_cs, ram_we, ram_addr, ram_wdata}), 32'd0);
    check("rst_rdata", 32'({vid_rdata, cpu_rdata, dma_rdata}), 32'd0);
    check("rst_acks", 32'({vid_ack, cpu_ack, dma_ack}), 32'd0);
    reset_in_n = 1'b1;
    tick();

    //        v     c     d     we    wprot chk   av         ac         ad         wd     rd     own   we    addr
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 17'h02000, 17'h00000, 17'h00000, 8'h00, 8'hA5, 2'd1, 1'b0, 17'h02000));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 17'h00000, 17'h0C080, 17'h00000, 8'h00, 8'h5A, 2'd2, 1'b0, 17'h0C080));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 17'h00000, 17'h1D000, 17'h00000, 8'h3C, 8'h00, 2'd2, 1'b1, 17'h1D000));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 17'h00000, 17'h1D001, 17'h00000, 8'hC3, 8'h00, 2'd2, 1'b0, 17'h1D001));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 17'h10400, 17'h00800, 17'h00000, 8'h99, 8'h3E, 2'd1, 1'b0, 17'h10400));
`ifdef RAM_ARB_DMA_EN
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 17'h00000, 17'h00000, 17'h10010, 8'h00, 8'h77, 2'd3, 1'b0, 17'h10010));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'h00000, 17'h00000, 17'h0A0A0, 8'h4B, 8'h00, 2'd3, 1'b1, 17'h0A0A0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 17'h00000, 17'h00300, 17'h00400, 8'h00, 8'h12, 2'd2, 1'b0, 17'h00300));
`endif
    foreach (vecs[i]) run_vec(vecs[i], i);

    // video and CPU together: video first, CPU in the next IDLE
    cpu_we = 1'b0; cpu_wprot = 1'b0;
    vid_addr = 17'h02000; cpu_addr = 17'h00123; ram_rdata = 8'h66;
    vid_req = 1'b1; cpu_req = 1'b1;
    tick();
    check("pri_owner_vid", 32'(owner), 32'd1);
    tick(); tick();
    check("pri_vid_ack", 32'(vid_ack), 32'd1);
    vid_req = 1'b0;
    exp_vid_rd = 8'h66;
    tick();
    check("pri_idle_c4", 32'(busy), 32'd0);
    tick();
    check("pri_owner_cpu", 32'(owner), 32'd2);
    tick();
    check("pri_cpu_ack_c6", 32'(cpu_ack), 32'd0);
    tick();
    check("pri_cpu_ack_c7", 32'(cpu_ack), 32'd1);
    check("pri_cpu_rdata", 32'(cpu_rdata), 32'h66);
    cpu_req = 1'b0;
    tick();

    // write-protected CPU write: no strobe, single ack
    cpu_addr = 17'h1D000; cpu_wdata = 8'h3C; cpu_we = 1'b1; cpu_wprot = 1'b1;
    cpu_req = 1'b1;
    we_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ram_we) we_cnt++;
      if (cpu_ack) begin ack_cnt++; cpu_req = 1'b0; end
    end
    check("wprot_we_cycles", 32'(we_cnt), 32'd0);
    check("wprot_ack_count", 32'(ack_cnt), 32'd1);
    cpu_we = 1'b0; cpu_wprot = 1'b0;

    // reset in the second ACCESS cycle of a CPU write
    cpu_addr = 17'h00400; cpu_wdata = 8'h11; cpu_we = 1'b1; cpu_req = 1'b1;
    tick();
    check("rstmid_we_c1", 32'(ram_we), 32'd1);
    tick();
    reset_in_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    check("rstmid_cs", 32'(ram_cs), 32'd0);
    check("rstmid_we", 32'(ram_we), 32'd0);
    check("rstmid_owner", 32'(owner), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_addr", 32'(ram_addr), 32'd0);
    ack_cnt = 0;
    for (int i = 0; i < 2; i++) begin tick(); if (cpu_ack) ack_cnt++; end
    reset_in_n = 1'b1;
    exp_vid_rd = '0;
    for (int i = 0; i < 3; i++) begin tick(); if (cpu_ack) ack_cnt++; end
    check("rstmid_no_ack", 32'(ack_cnt), 32'd0);
    check("rstmid_vid_rd", 32'(vid_rdata), 32'(exp_vid_rd));

`ifdef RAM_ARB_DMA_EN
    // CPU and DMA held continuously: four CPU grants, then DMA, then CPU
    exp_q = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2};
    cpu_addr = 17'h00010; dma_addr = 17'h00020; ram_rdata = 8'h01;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int g = 0; g < 6; g++) begin
      logic [1:0] e;
      tick();
      e = exp_q.pop_front();
      check($sformatf("starve_g%0d", g), 32'(owner), 32'(e));
      tick(); tick();
      if (g == 5) begin cpu_req = 1'b0; dma_req = 1'b0; end
      tick();
    end
    check("starve_idle", 32'(busy), 32'd0);
`else
    // DMA disabled: dma_req alone must never start an access
    dma_addr = 17'h00055; dma_req = 1'b1;
    busy_cnt = 0; ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (dma_ack) ack_cnt++;
    end
    dma_req = 1'b0;
    check("nodma_busy", 32'(busy_cnt), 32'd0);
    check("nodma_ack", 32'(ack_cnt), 32'd0);
    check("nodma_rdata", 32'(dma_rdata), 32'd0);
    check("nodma_owner", 32'(owner), 32'd0);
`endif

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
